mem_pipe_slave: RTL and testbench

Parametrised single-port memory slave with a valid/ready request handshake, byte-strobed writes, configurable read latency, and a backpressurable read-response channel. It replaces the flat wr_en/valid/ready memory DUT as the memory target behind the memory interface in the testbench environment. It supports programmable pipeline depth and never drops a read response when the consumer stalls.

---
 rtl/mem_pipe_slave_pkg.sv | 26 ++
 rtl/mem_pipe_slave_if.sv | 27 ++
 rtl/mem_pipe_slave_resp_fifo.sv | 55 +++++
 rtl/mem_pipe_slave.sv | 120 ++++++++++++
 tb/tb_mem_pipe_slave.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pipe_slave_pkg.sv
// mem_pkg: shared widths, latency limit and request/response types for
// mem_pipe_slave. Optional range checking is selected by MEM_OOR_CHECK_EN.
package mem_pkg;

   localparam int MEM_WIDTH      = 32;
   localparam int MEM_ADDR_WIDTH = 8;
   localparam int RD_LAT_MAX     = 4;

   typedef struct packed {
      logic [MEM_WIDTH-1:0] data;
      logic                 err;
   } mem_resp_t;

   typedef struct packed {
      logic                      wr_en;
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [MEM_WIDTH-1:0]      wdata;
      logic [MEM_WIDTH/8-1:0]    wstrb;
   } mem_req_t;

   // Pointer advance with wrap at an arbitrary (non power-of-two) depth.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/mem_pipe_slave_if.sv
// Request/response bus between a memory master and mem_pipe_slave.
// Range checking in the slave is selected by MEM_OOR_CHECK_EN.
interface mem_pipe_slave_if import mem_pkg::*; #(
   parameter int WIDTH      = MEM_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
   logic                  valid;
   logic                  ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH/8-1:0]    wstrb;
   logic [WIDTH-1:0]      rdata;
   logic                  rvalid;
   logic                  rready;
   logic                  rerr;

   modport master (
      output valid, wr_en, addr, wdata, wstrb, rready,
      input  ready, rdata, rvalid, rerr
   );

   modport slave (
      input  valid, wr_en, addr, wdata, wstrb, rready,
      output ready, rdata, rvalid, rerr
   );
endinterface

// File: rtl/mem_pipe_slave_resp_fifo.sv
// mem_resp_fifo: synchronous response FIFO with count-based full/empty so
// that any depth (including non power-of-two) is handled.
// Used by mem_pipe_slave; MEM_OOR_CHECK_EN does not affect this file.
module mem_resp_fifo import mem_pkg::*; #(
   parameter int  DEPTH = 3,
   parameter type T     = mem_resp_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Next pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = PW'(next_ptr(32'(wr_ptr_q), DEPTH));
      if (do_pop)  rd_ptr_d = PW'(next_ptr(32'(rd_ptr_q), DEPTH));
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   // State and storage registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= data_i;
      end
   end
endmodule

// File: rtl/mem_pipe_slave.sv
// mem_pipe_slave: single-port memory target with valid/ready requests,
// byte-strobed writes, RD_LAT-stage read pipeline, credit-guarded response
// FIFO. Define MEM_OOR_CHECK_EN to drop out-of-range writes and flag
// out-of-range reads with rerr; otherwise DEPTH must be 2**ADDR_WIDTH.
module mem_pipe_slave import mem_pkg::*; #(
   parameter int WIDTH      = MEM_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DEPTH      = 256,
   parameter int RD_LAT     = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_pipe_slave_if.slave  bus
);
   localparam int NB      = WIDTH / 8;
   localparam int CREDITS = RD_LAT + 1;
   localparam int OW      = $clog2(CREDITS + 1);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } resp_t;

   if ((WIDTH % 8) != 0 || RD_LAT < 1 || RD_LAT > RD_LAT_MAX || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_param
      $error("mem_pipe_slave: illegal WIDTH/RD_LAT/DEPTH");
   end
`ifndef MEM_OOR_CHECK_EN
   if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("mem_pipe_slave: DEPTH must equal 2**ADDR_WIDTH without range checking");
   end
`endif

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             init_q;
   logic [OW-1:0]    outst_q, outst_d;
   logic             pipe_vld_q [RD_LAT];
   resp_t            pipe_q     [RD_LAT];
   resp_t            rd_resp, fifo_head;
   logic             fifo_full, fifo_empty;
   logic             accept, rd_acc, pop, oor;

   // A full FIFO being popped frees its credit in the same cycle.
   assign pop       = !fifo_empty && bus.rready;
   assign bus.ready = init_q && ((outst_q < OW'(CREDITS)) || (fifo_full && pop));
   assign accept    = bus.valid && bus.ready;
   assign rd_acc    = accept && !bus.wr_en;

`ifdef MEM_OOR_CHECK_EN
   assign oor = (32'(bus.addr) >= 32'(DEPTH));
`else
   assign oor = 1'b0;
`endif

   assign rd_resp.data = oor ? '0 : mem_q[bus.addr];
   assign rd_resp.err  = oor;

   assign bus.rvalid = !fifo_empty;
   assign bus.rdata  = fifo_empty ? '0 : fifo_head.data;
   assign bus.rerr   = !fifo_empty && fifo_head.err;

   // Byte-strobed array write; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      if (accept && bus.wr_en && !oor) begin
         for (int unsigned i = 0; i < NB; i++)
            if (bus.wstrb[i]) mem_q[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
   end

   // Read pipeline: stage 0 holds the array sample taken at the accept edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_q[i]     <= '0;
         end
      end else begin
         pipe_vld_q[0] <= rd_acc;
         pipe_q[0]     <= rd_resp;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_q[i]     <= pipe_q[i-1];
         end
      end
   end

   // Credit counter over reads in the pipe plus reads in the FIFO.
   always_comb begin
      outst_d = outst_q;
      case ({rd_acc, pop})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase
   end

   // Credit and post-reset ready-enable registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outst_q <= '0;
         init_q  <= 1'b0;
      end else begin
         outst_q <= outst_d;
         init_q  <= 1'b1;
      end
   end

   mem_resp_fifo #(
      .DEPTH (CREDITS),
      .T     (resp_t)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pipe_vld_q[RD_LAT-1]),
      .data_i  (pipe_q[RD_LAT-1]),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
endmodule

// File: tb/tb_mem_pipe_slave.sv
// Bench for mem_pipe_slave: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model (word array + queue of
// expected responses with their earliest visible cycle).
// Define MEM_OOR_CHECK_EN to build with DEPTH=200 and range checks.
module tb_mem_pipe_slave;
   import mem_pkg::*;

   localparam int WIDTH  = 32;
   localparam int AW     = 8;
   localparam int RD_LAT = 2;
`ifdef MEM_OOR_CHECK_EN
   localparam int DEPTH  = 200;
`else
   localparam int DEPTH  = 256;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          avail;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_pipe_slave_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   mem_pipe_slave #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        q[$];
   logic [31:0] mm [256];
   int          cyc = 0;
   bit          en = 0;
   bit          last_acc = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input bit we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      bus.valid = v; bus.wr_en = we; bus.addr = a; bus.wdata = d; bus.wstrb = s;
   endtask

   // One clock: compare outputs against the model, then advance the model.
   task automatic tick();
      bit   exp_rv, exp_full, pop, exp_rdy, acc, oor;
      exp_t e;
      #1;
      exp_rv   = (q.size() > 0) && (cyc >= q[0].avail);
      exp_full = (q.size() == RD_LAT + 1) && (cyc >= q[$].avail);
      pop      = exp_rv && bus.rready;
      exp_rdy  = en && rst && ((q.size() < RD_LAT + 1) || (exp_full && pop));
      chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
      chk("ready", 32'(bus.ready), 32'(exp_rdy));
      if (exp_rv) begin
         chk("rdata", bus.rdata, q[0].data);
         chk("rerr", 32'(bus.rerr), 32'(q[0].err));
      end
      acc = bus.valid && exp_rdy;
      @(posedge clk);
      cyc++;
      if (pop) void'(q.pop_front());
      if (acc) begin
         oor = int'(bus.addr) >= DEPTH;
         if (bus.wr_en) begin
            if (!oor)
               for (int b = 0; b < 4; b++)
                  if (bus.wstrb[b]) mm[bus.addr][8*b +: 8] = bus.wdata[8*b +: 8];
         end else begin
            e.data  = oor ? 32'h0 : mm[bus.addr];
            e.err   = oor;
            e.avail = cyc + RD_LAT;
            q.push_back(e);
         end
      end
      if (rst) en = 1;
      last_acc = acc;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      q.delete();
      en = 0;
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_ready", 32'(bus.ready), 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_rerr", 32'(bus.rerr), 32'h0);
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      tick();
      rst = 1'b1;
   endtask

   // Idle until a response is visible (bounded), then check it against constants.
   task automatic expect_head(input string tag, input logic [31:0] d, input logic e);
      int n = 0;
      #1;
      while (!bus.rvalid && n < 20) begin
         tick();
         #1;
         n++;
      end
      chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'h1);
      chk({tag, "_rdata"}, bus.rdata, d);
      chk({tag, "_rerr"}, 32'(bus.rerr), 32'(e));
   endtask

   initial begin
      int n, m;
      bus.rready = 1'b1;
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      #3;
      do_reset();

      // Back-to-back alternating write/read over addresses 0..63.
      for (int i = 0; i < 64; i++) begin
         drive(1, 1, 8'(i), $urandom, 4'hF); tick();
         drive(1, 0, 8'(i), 32'h0, 4'h0);    tick();
      end
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      repeat (6) tick();

      // Write then read the same word.
      drive(1, 1, 8'h10, 32'hDEADBEEF, 4'hF); tick();
      drive(1, 0, 8'h10, 32'h0, 4'h0);        tick();
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      expect_head("wr_rd", 32'hDEADBEEF, 1'b0);
      tick();

      // Byte strobes.
      drive(1, 1, 8'h05, 32'h11223344, 4'hF); tick();
      drive(1, 1, 8'h05, 32'hAABBCCDD, 4'h5); tick();
      drive(1, 0, 8'h05, 32'h0, 4'h0);        tick();
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      expect_head("strobe", 32'h11BB33DD, 1'b0);
      tick();

      // Backpressure: only RD_LAT+1 reads fit while rready is low.
      bus.rready = 1'b0;
      n = 0;
      for (int i = 0; i < 2 * (RD_LAT + 1); i++) begin
         drive(1, 0, 8'($urandom_range(0, 63)), 32'h0, 4'h0);
         tick();
         if (last_acc) n++;
      end
      chk("bp_accepted", 32'(n), 32'(RD_LAT + 1));
      #1;
      chk("bp_ready_low", 32'(bus.ready), 32'h0);
      bus.rready = 1'b1;
      m = 0;
      for (int i = 0; i < 30 && m < RD_LAT + 1; i++) begin
         tick();
         if (last_acc) m++;
      end
      chk("bp_rest", 32'(m), 32'(RD_LAT + 1));
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      repeat (10) tick();

      // Reset with three reads in flight; nothing stale may appear afterwards.
      bus.rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 8'(i), 32'h0, 4'h0);
         tick();
      end
      do_reset();
      bus.rready = 1'b1;
      repeat (8) tick();

`ifdef MEM_OOR_CHECK_EN
      // Out-of-range write dropped, read flagged; in-range neighbours unaffected.
      drive(1, 1, 8'd210, 32'h0000CAFE, 4'hF); tick();
      drive(1, 1, 8'd199, 32'h12345678, 4'hF); tick();
      drive(1, 0, 8'd210, 32'h0, 4'h0);        tick();
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      expect_head("oor_rd", 32'h0, 1'b1);
      tick();
      drive(1, 0, 8'd199, 32'h0, 4'h0); tick();
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      expect_head("last_rd", 32'h12345678, 1'b0);
      tick();
      drive(1, 0, 8'd10, 32'h0, 4'h0); tick();
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      expect_head("alias_rd", mm[10], 1'b0);
      tick();
`endif

      // Random traffic with random response backpressure.
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 63));
`ifdef MEM_OOR_CHECK_EN
         if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(200, 255));
`endif
         drive($urandom_range(0, 9) < 7, 1'($urandom), a, $urandom, 4'($urandom));
         bus.rready = $urandom_range(0, 9) < 7;
         if (i == 1000) do_reset();
         else tick();
      end
      drive(0, 0, 8'h0, 32'h0, 4'h0);
      bus.rready = 1'b1;
      repeat (12) tick();
      #1;
      chk("final_rvalid", 32'(bus.rvalid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
